// File: rtl/xintf_ram_arbiter.sv
// xintf_ram_arbiter
// Shares the PL-side port of the XINTF DPBRAM between three requesters:
//   0 = DSP-sync readback sequencer, 1 = PS/EPICS write-index path, 2 = waveform copy.
// One round-robin grant per cycle, writes held off while the DSP owns the data
// window, and read data steered back to its requester after RD_LAT cycles.
module xintf_ram_arbiter #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned DEPTH  = 500,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_hold,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_req2,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic              i_we2,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [ADDR_W-1:0] i_addr2,
    input  logic [DATA_W-1:0] i_din0,
    input  logic [DATA_W-1:0] i_din1,
    input  logic [DATA_W-1:0] i_din2,
    output logic              o_gnt0,
    output logic              o_gnt1,
    output logic              o_gnt2,
    output logic              o_rvalid0,
    output logic              o_rvalid1,
    output logic              o_rvalid2,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_err,
    output logic              o_busy,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_ce,
    output logic              o_ram_we,
    output logic [DATA_W-1:0] o_ram_din,
    input  logic [DATA_W-1:0] i_ram_dout
);

    // Addresses at or above this limit are rejected without touching the BRAM
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH);

    // Modulo-3 increment used for both the search order and the pointer update
    function automatic logic [1:0] inc3(input logic [1:0] v);
        return (v == 2'd2) ? 2'd0 : v + 2'd1;
    endfunction

    logic [2:0]        req;
    logic [2:0]        we;
    logic [2:0]        elig;
    logic [2:0]        rot;
    logic              win_valid;
    logic [1:0]        win_id;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] din_sel;
    logic              out_of_range;

    logic [1:0]        ptr, ptr_nxt;
    logic [2:0]        gnt, gnt_nxt;
    logic              ram_ce, ram_ce_nxt;
    logic              ram_we, ram_we_nxt;
    logic [ADDR_W-1:0] ram_addr, ram_addr_nxt;
    logic [DATA_W-1:0] ram_din, ram_din_nxt;
    logic              err, err_nxt;
    logic              issue_rd, issue_rd_nxt;
    logic              issue_oor, issue_oor_nxt;
    logic [1:0]        issue_id, issue_id_nxt;

    logic [RD_LAT-1:0]      rd_vld;
    logic [RD_LAT-1:0]      rd_oor;
    logic [RD_LAT-1:0][1:0] rd_id;
    logic                   head_vld;
    logic                   head_oor;
    logic [1:0]             head_id;
    logic [2:0]             rvalid;
    logic [DATA_W-1:0]      rdata_cur;
    logic [DATA_W-1:0]      rdata_hold;

    assign req = {i_req2, i_req1, i_req0};
    assign we  = {i_we2, i_we1, i_we0};

    // A requester granted this cycle is masked so its stale request is not re-granted
    assign elig = req & ~gnt & ~(we & {3{i_hold}});

    // Rotate eligibility so that bit 0 is the requester at the pointer
    always_comb begin
        unique case (ptr)
            2'd1:    rot = {elig[0], elig[2], elig[1]};
            2'd2:    rot = {elig[1], elig[0], elig[2]};
            default: rot = elig;
        endcase
    end

    // Pick the first eligible requester in the order ptr, ptr+1, ptr+2
    always_comb begin
        win_valid = |rot;
        win_id    = ptr;
        if (rot[0]) begin
            win_id = ptr;
        end else if (rot[1]) begin
            win_id = inc3(ptr);
        end else if (rot[2]) begin
            win_id = inc3(inc3(ptr));
        end
    end

    // Select the winner's access fields
    always_comb begin
        unique case (win_id)
            2'd1: begin
                we_sel   = i_we1;
                addr_sel = i_addr1;
                din_sel  = i_din1;
            end
            2'd2: begin
                we_sel   = i_we2;
                addr_sel = i_addr2;
                din_sel  = i_din2;
            end
            default: begin
                we_sel   = i_we0;
                addr_sel = i_addr0;
                din_sel  = i_din0;
            end
        endcase
    end

    assign out_of_range = {1'b0, addr_sel} >= DEPTH_LIM;

    // Next-state for the grant stage; everything here lasts exactly one cycle
    always_comb begin
        ptr_nxt       = ptr;
        gnt_nxt       = 3'b000;
        ram_ce_nxt    = 1'b0;
        ram_we_nxt    = 1'b0;
        ram_addr_nxt  = '0;
        ram_din_nxt   = '0;
        err_nxt       = 1'b0;
        issue_rd_nxt  = 1'b0;
        issue_oor_nxt = 1'b0;
        issue_id_nxt  = 2'd0;
        if (win_valid) begin
            unique case (win_id)
                2'd1:    gnt_nxt = 3'b010;
                2'd2:    gnt_nxt = 3'b100;
                default: gnt_nxt = 3'b001;
            endcase
            ptr_nxt       = inc3(win_id);
            // Out-of-range accesses are granted but kept off the BRAM
            ram_ce_nxt    = ~out_of_range;
            ram_we_nxt    = we_sel & ~out_of_range;
            ram_addr_nxt  = addr_sel;
            ram_din_nxt   = din_sel;
            err_nxt       = out_of_range;
            issue_rd_nxt  = ~we_sel;
            issue_oor_nxt = out_of_range;
            issue_id_nxt  = win_id;
        end
    end

    // Grant stage and round-robin pointer registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr       <= 2'd0;
            gnt       <= 3'b000;
            ram_ce    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_din   <= '0;
            err       <= 1'b0;
            issue_rd  <= 1'b0;
            issue_oor <= 1'b0;
            issue_id  <= 2'd0;
        end else begin
            ptr       <= ptr_nxt;
            gnt       <= gnt_nxt;
            ram_ce    <= ram_ce_nxt;
            ram_we    <= ram_we_nxt;
            ram_addr  <= ram_addr_nxt;
            ram_din   <= ram_din_nxt;
            err       <= err_nxt;
            issue_rd  <= issue_rd_nxt;
            issue_oor <= issue_oor_nxt;
            issue_id  <= issue_id_nxt;
        end
    end

    // Track requester id of each read through the BRAM latency
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_vld <= '0;
            rd_oor <= '0;
            rd_id  <= '0;
        end else begin
            rd_vld[0] <= issue_rd;
            rd_oor[0] <= issue_oor;
            rd_id[0]  <= issue_id;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                rd_vld[i] <= rd_vld[i-1];
                rd_oor[i] <= rd_oor[i-1];
                rd_id[i]  <= rd_id[i-1];
            end
        end
    end

    assign head_vld  = rd_vld[RD_LAT-1];
    assign head_oor  = rd_oor[RD_LAT-1];
    assign head_id   = rd_id[RD_LAT-1];
    // A rejected read returns zero instead of whatever the BRAM last drove
    assign rdata_cur = head_oor ? '0 : i_ram_dout;

    // Route the returning read to its requester
    always_comb begin
        rvalid = 3'b000;
        if (head_vld) begin
            unique case (head_id)
                2'd1:    rvalid = 3'b010;
                2'd2:    rvalid = 3'b100;
                default: rvalid = 3'b001;
            endcase
        end
    end

    // Keep the last returned word on o_rdata between read responses
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdata_hold <= '0;
        end else if (head_vld) begin
            rdata_hold <= rdata_cur;
        end
    end

    assign o_rdata    = head_vld ? rdata_cur : rdata_hold;
    assign o_rvalid0  = rvalid[0];
    assign o_rvalid1  = rvalid[1];
    assign o_rvalid2  = rvalid[2];
    assign o_gnt0     = gnt[0];
    assign o_gnt1     = gnt[1];
    assign o_gnt2     = gnt[2];
    assign o_err      = err;
    assign o_ram_ce   = ram_ce;
    assign o_ram_we   = ram_we;
    assign o_ram_addr = ram_addr;
    assign o_ram_din  = ram_din;
    assign o_busy     = (|req) | (|rd_vld) | (|gnt);

endmodule

// File: tb/tb_xintf_ram_arbiter.sv
// tb_xintf_ram_arbiter
// Drives two arbiters (RD_LAT = 1 and RD_LAT = 3) from the same requests, each with
// its own BRAM model; expected grants and read returns go into scoreboard queues.
module tb_xintf_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        hold;
    logic        req0, req1, req2;
    logic        we0, we1, we2;
    logic [8:0]  addr0, addr1, addr2;
    logic [15:0] din0, din1, din2;

    logic        g0_a, g1_a, g2_a, rv0_a, rv1_a, rv2_a, err_a, busy_a, ce_a, we_a;
    logic [15:0] rdata_a, din_a, dout_a;
    logic [8:0]  addr_a;
    logic        g0_b, g1_b, g2_b, rv0_b, rv1_b, rv2_b, err_b, busy_b, ce_b, we_b;
    logic [15:0] rdata_b, din_b, dout_b;
    logic [8:0]  addr_b;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int          cyc;
        logic [2:0]  gnt;
        logic        err;
        logic        ce;
        logic        we;
        logic [8:0]  addr;
        logic [15:0] din;
    } gnt_t;

    typedef struct {
        int          cyc;
        logic [2:0]  id1h;
        logic [15:0] data;
    } rd_t;

    gnt_t gq_a[$], gq_b[$];
    rd_t  rq_a[$], rq_b[$];
    gnt_t ge_a, ge_b;
    rd_t  re_a, re_b;
    logic [15:0] last_a, last_b;
    logic        prev_a, prev_b;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    xintf_ram_arbiter #(.ADDR_W(9), .DATA_W(16), .DEPTH(500), .RD_LAT(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_hold(hold),
        .i_req0(req0), .i_req1(req1), .i_req2(req2),
        .i_we0(we0), .i_we1(we1), .i_we2(we2),
        .i_addr0(addr0), .i_addr1(addr1), .i_addr2(addr2),
        .i_din0(din0), .i_din1(din1), .i_din2(din2),
        .o_gnt0(g0_a), .o_gnt1(g1_a), .o_gnt2(g2_a),
        .o_rvalid0(rv0_a), .o_rvalid1(rv1_a), .o_rvalid2(rv2_a),
        .o_rdata(rdata_a), .o_err(err_a), .o_busy(busy_a),
        .o_ram_addr(addr_a), .o_ram_ce(ce_a), .o_ram_we(we_a), .o_ram_din(din_a),
        .i_ram_dout(dout_a)
    );

    xintf_ram_arbiter #(.ADDR_W(9), .DATA_W(16), .DEPTH(500), .RD_LAT(3)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_hold(hold),
        .i_req0(req0), .i_req1(req1), .i_req2(req2),
        .i_we0(we0), .i_we1(we1), .i_we2(we2),
        .i_addr0(addr0), .i_addr1(addr1), .i_addr2(addr2),
        .i_din0(din0), .i_din1(din1), .i_din2(din2),
        .o_gnt0(g0_b), .o_gnt1(g1_b), .o_gnt2(g2_b),
        .o_rvalid0(rv0_b), .o_rvalid1(rv1_b), .o_rvalid2(rv2_b),
        .o_rdata(rdata_b), .o_err(err_b), .o_busy(busy_b),
        .o_ram_addr(addr_b), .o_ram_ce(ce_b), .o_ram_we(we_b), .o_ram_din(din_b),
        .i_ram_dout(dout_b)
    );

    // Preload pattern: BRAM[10] = 1234, everything else C000 | addr
    function automatic logic [15:0] init_val(input int a);
        logic [15:0] v;
        v = 16'hC000 | 16'(a);
        if (a == 10) v = 16'h1234;
        return v;
    endfunction

    // BRAM models: latency 1 for dut_a, latency 3 for dut_b
    logic [15:0] mem_a [512];
    logic [15:0] mem_b [512];
    logic [15:0] pb0, pb1, pb2;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) mem_a[i] <= init_val(i);
        end else if (ce_a) begin
            if (we_a) mem_a[addr_a] <= din_a;
            dout_a <= mem_a[addr_a];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 512; i++) mem_b[i] <= init_val(i);
        end else if (ce_b) begin
            if (we_b) mem_b[addr_b] <= din_b;
            pb0 <= mem_b[addr_b];
        end
        pb1 <= pb0;
        pb2 <= pb1;
    end
    assign dout_b = pb2;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
        n_vec++;
        if (got !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got an unexpected event, required none (cycle %0d)", name, cyc);
    endtask

    function automatic logic [63:0] pack_g(input int c, input logic [2:0] g, input logic e,
                                           input logic ce, input logic w, input logic [8:0] a,
                                           input logic [15:0] d);
        return {1'b0, 32'(c), g, e, ce, w, a, d};
    endfunction

    function automatic logic [63:0] pack_r(input int c, input logic [2:0] v,
                                           input logic [15:0] d);
        return {13'd0, 32'(c), v, d};
    endfunction

    // Push expected grant (and read return, if any) into both scoreboards
    task automatic issue(input int id, input logic w, input logic [8:0] a, input logic [15:0] d,
                         input int gc, input logic [15:0] rd, input bit want_rd);
        gnt_t g;
        rd_t  r;
        g.cyc  = gc;
        g.gnt  = 3'b001 << id;
        g.err  = (a >= 9'd500);
        g.ce   = ~g.err;
        g.we   = w & ~g.err;
        g.addr = a;
        g.din  = d;
        gq_a.push_back(g);
        gq_b.push_back(g);
        if (!w && want_rd) begin
            r.cyc  = gc;
            r.id1h = g.gnt;
            r.data = g.err ? 16'h0000 : rd;
            rq_a.push_back(r);
            rq_b.push_back(r);
        end
    endtask

    task automatic set_req(input int id, input logic r, input logic w, input logic [8:0] a,
                           input logic [15:0] d);
        case (id)
            0: begin req0 = r; we0 = w; addr0 = a; din0 = d; end
            1: begin req1 = r; we1 = w; addr1 = a; din1 = d; end
            default: begin req2 = r; we2 = w; addr2 = a; din2 = d; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for dut_a
    always @(negedge clk) begin
        if (rst) begin
            last_a = 16'h0;
            prev_a = 1'b0;
        end else begin
            if ({g2_a, g1_a, g0_a} != 3'b000 || err_a || ce_a || we_a) begin
                if (gq_a.size() == 0) begin
                    fail_now("gnt_a_unexpected");
                end else begin
                    ge_a = gq_a.pop_front();
                    check("gnt_a", pack_g(cyc, {g2_a, g1_a, g0_a}, err_a, ce_a, we_a, addr_a, din_a),
                          pack_g(ge_a.cyc, ge_a.gnt, ge_a.err, ge_a.ce, ge_a.we, ge_a.addr,
                                 ge_a.din));
                end
            end
            if ({rv2_a, rv1_a, rv0_a} != 3'b000) begin
                if (rq_a.size() == 0) begin
                    fail_now("rvalid_a_unexpected");
                end else begin
                    re_a = rq_a.pop_front();
                    check("rvalid_a", pack_r(cyc, {rv2_a, rv1_a, rv0_a}, rdata_a),
                          pack_r(re_a.cyc + 1, re_a.id1h, re_a.data));
                end
                last_a = rdata_a;
                prev_a = 1'b1;
            end else begin
                if (prev_a) check("rdata_hold_a", 64'(rdata_a), 64'(last_a));
                prev_a = 1'b0;
            end
        end
    end

    // Monitor for dut_b
    always @(negedge clk) begin
        if (rst) begin
            last_b = 16'h0;
            prev_b = 1'b0;
        end else begin
            if ({g2_b, g1_b, g0_b} != 3'b000 || err_b || ce_b || we_b) begin
                if (gq_b.size() == 0) begin
                    fail_now("gnt_b_unexpected");
                end else begin
                    ge_b = gq_b.pop_front();
                    check("gnt_b", pack_g(cyc, {g2_b, g1_b, g0_b}, err_b, ce_b, we_b, addr_b, din_b),
                          pack_g(ge_b.cyc, ge_b.gnt, ge_b.err, ge_b.ce, ge_b.we, ge_b.addr,
                                 ge_b.din));
                end
            end
            if ({rv2_b, rv1_b, rv0_b} != 3'b000) begin
                if (rq_b.size() == 0) begin
                    fail_now("rvalid_b_unexpected");
                end else begin
                    re_b = rq_b.pop_front();
                    check("rvalid_b", pack_r(cyc, {rv2_b, rv1_b, rv0_b}, rdata_b),
                          pack_r(re_b.cyc + 3, re_b.id1h, re_b.data));
                end
                last_b = rdata_b;
                prev_b = 1'b1;
            end else begin
                if (prev_b) check("rdata_hold_b", 64'(rdata_b), 64'(last_b));
                prev_b = 1'b0;
            end
        end
    end

    // Directed stimulus
    initial begin
        int base;
        rst  = 1'b1;
        hold = 1'b0;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        set_req(2, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outs_a", 64'({g0_a, g1_a, g2_a, rv0_a, rv1_a, rv2_a, rdata_a, err_a, busy_a,
                                   addr_a, ce_a, we_a, din_a}), 64'(0));
        check("reset_outs_b", 64'({g0_b, g1_b, g2_b, rv0_b, rv1_b, rv2_b, rdata_b, err_b, busy_b,
                                   addr_b, ce_b, we_b, din_b}), 64'(0));
        rst = 1'b0;
        tick();

        // Single read of BRAM[10]; pointer 0 -> 1
        set_req(0, 1, 0, 9'd10, 16'h0);
        issue(0, 0, 9'd10, 16'h0, cyc + 1, 16'h1234, 1);
        #1;
        check("busy_with_req", 64'({busy_a, busy_b}), 64'(2'b11));
        tick();
        set_req(0, 0, 0, 0, 0);
        repeat (4) tick();

        // Last valid address, normal access; pointer 1 -> 0
        set_req(2, 1, 0, 9'd499, 16'h0);
        issue(2, 0, 9'd499, 16'h0, cyc + 1, 16'hC1F3, 1);
        tick();
        set_req(2, 0, 0, 0, 0);
        repeat (4) tick();

        // All three held, reads: 0,1,2,0,1,2 on consecutive cycles
        base = cyc;
        set_req(0, 1, 0, 9'd20, 16'h0);
        set_req(1, 1, 0, 9'd21, 16'h0);
        set_req(2, 1, 0, 9'd22, 16'h0);
        issue(0, 0, 9'd20, 16'h0, base + 1, 16'hC014, 1);
        issue(1, 0, 9'd21, 16'h0, base + 2, 16'hC015, 1);
        issue(2, 0, 9'd22, 16'h0, base + 3, 16'hC016, 1);
        issue(0, 0, 9'd20, 16'h0, base + 4, 16'hC014, 1);
        issue(1, 0, 9'd21, 16'h0, base + 5, 16'hC015, 1);
        issue(2, 0, 9'd22, 16'h0, base + 6, 16'hC016, 1);
        repeat (4) tick();
        set_req(0, 0, 0, 0, 0);
        tick();
        set_req(1, 0, 0, 0, 0);
        tick();
        set_req(2, 0, 0, 0, 0);
        repeat (5) tick();

        // Hold blocks the write but not the read; write goes once hold drops
        base = cyc;
        hold = 1'b1;
        set_req(1, 1, 1, 9'd5, 16'hBEEF);
        set_req(2, 1, 0, 9'd6, 16'h0);
        issue(2, 0, 9'd6, 16'h0, base + 1, 16'hC006, 1);
        tick();
        set_req(2, 0, 0, 0, 0);
        repeat (2) tick();
        hold = 1'b0;
        issue(1, 1, 9'd5, 16'hBEEF, base + 4, 16'h0, 0);
        tick();
        set_req(1, 0, 0, 0, 0);
        tick();
        set_req(0, 1, 0, 9'd5, 16'h0);
        issue(0, 0, 9'd5, 16'h0, base + 6, 16'hBEEF, 1);
        tick();
        set_req(0, 0, 0, 0, 0);
        repeat (5) tick();

        // Write registered just before hold rises still completes; read back under hold
        base = cyc;
        set_req(0, 1, 1, 9'd7, 16'hCAFE);
        issue(0, 1, 9'd7, 16'hCAFE, base + 1, 16'h0, 0);
        tick();
        hold = 1'b1;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 1, 0, 9'd7, 16'h0);
        issue(1, 0, 9'd7, 16'h0, base + 2, 16'hCAFE, 1);
        tick();
        set_req(1, 0, 0, 0, 0);
        hold = 1'b0;
        repeat (5) tick();

        // Out-of-range read and write: granted, err pulses, BRAM untouched
        base = cyc;
        set_req(2, 1, 0, 9'd500, 16'h0);
        issue(2, 0, 9'd500, 16'h0, base + 1, 16'h0, 1);
        tick();
        set_req(2, 0, 0, 0, 0);
        set_req(1, 1, 1, 9'd510, 16'h1111);
        issue(1, 1, 9'd510, 16'h1111, base + 2, 16'h0, 0);
        tick();
        set_req(1, 0, 0, 0, 0);
        repeat (5) tick();

        // Back-to-back reads req0 addr 1 then req1 addr 2
        base = cyc;
        set_req(0, 1, 0, 9'd1, 16'h0);
        set_req(1, 1, 0, 9'd2, 16'h0);
        issue(0, 0, 9'd1, 16'h0, base + 1, 16'hC001, 1);
        issue(1, 0, 9'd2, 16'h0, base + 2, 16'hC002, 1);
        tick();
        set_req(0, 0, 0, 0, 0);
        tick();
        set_req(1, 0, 0, 0, 0);
        repeat (6) tick();
        check("idle_busy", 64'({busy_a, busy_b}), 64'(0));

        // Reset one cycle after a read grant: the read never returns
        base = cyc;
        set_req(0, 1, 0, 9'd3, 16'h0);
        issue(0, 0, 9'd3, 16'h0, base + 1, 16'h0, 0);
        tick();
        set_req(0, 0, 0, 0, 0);
        tick();
        rst = 1'b1;
        #1;
        check("midreset_outs_a", 64'({g0_a, g1_a, g2_a, rv0_a, rv1_a, rv2_a, rdata_a, err_a,
                                      busy_a, addr_a, ce_a, we_a, din_a}), 64'(0));
        check("midreset_outs_b", 64'({g0_b, g1_b, g2_b, rv0_b, rv1_b, rv2_b, rdata_b, err_b,
                                      busy_b, addr_b, ce_b, we_b, din_b}), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        // Pointer back at 0: req0 beats req2
        base = cyc;
        set_req(0, 1, 0, 9'd4, 16'h0);
        set_req(2, 1, 0, 9'd8, 16'h0);
        issue(0, 0, 9'd4, 16'h0, base + 1, 16'hC004, 1);
        issue(2, 0, 9'd8, 16'h0, base + 2, 16'hC008, 1);
        tick();
        set_req(0, 0, 0, 0, 0);
        tick();
        set_req(2, 0, 0, 0, 0);
        repeat (8) tick();

        check("leftover_gnt_a", 64'(gq_a.size()), 64'(0));
        check("leftover_gnt_b", 64'(gq_b.size()), 64'(0));
        check("leftover_rd_a", 64'(rq_a.size()), 64'(0));
        check("leftover_rd_b", 64'(rq_b.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/xintf_ram_arbiter.md
Name: xintf_ram_arbiter

Overview:
- Shares the single PL-side (Zynq clock) port of the XINTF DPBRAM (depth 500 x 16 bit) between three requesters:
  - req0: the DSP-sync readback sequencer.
  - req1: the PS/EPICS write-index path.
  - req2: the waveform copy path.
- Grants are issued round-robin, one BRAM access per cycle.
- Writes are held off while the DSP owns the data window.
- Read data is routed back to the originating requester after the BRAM read latency.

Parameters:
ADDR_W, 9, BRAM address width
DATA_W, 16, BRAM data width
DEPTH, 500, valid address range 0..DEPTH-1
RD_LAT, 1, BRAM read latency in cycles from ce to valid dout (1..4)

Ports:
i_clk  in  1  system clock (s00_axi_aclk domain)
i_rst  in  1  asynchronous reset, active-high
i_hold  in  1  DSP window active; write grants blocked while high
i_req0/i_req1/i_req2  in  1 each  access request; held until matching o_gnt
i_we0/i_we1/i_we2  in  1 each  1 = write, 0 = read
i_addr0/i_addr1/i_addr2  in  ADDR_W each  access address
i_din0/i_din1/i_din2  in  DATA_W each  write data
o_gnt0/o_gnt1/o_gnt2  out  1 each  one-cycle grant pulse
o_rvalid0/o_rvalid1/o_rvalid2  out  1 each  read data valid for that requester
o_rdata  out  DATA_W  shared read data
o_err  out  1  one-cycle pulse: granted access had addr >= DEPTH
o_busy  out  1  any request pending or read in flight
o_ram_addr  out  ADDR_W  BRAM address
o_ram_ce  out  1  BRAM enable
o_ram_we  out  1  BRAM write enable
o_ram_din  out  DATA_W  BRAM write data
i_ram_dout  in  DATA_W  BRAM read data

Behaviour:
- Reset values:
  - All outputs 0, including o_rdata.
  - Round-robin pointer = 0, so req0 has first priority.
  - Read-tracking pipeline cleared.
- Eligibility in cycle N (all must hold):
  - i_reqK = 1.
  - o_gntK = 0 in cycle N (masking prevents double grant on a stale request).
  - Not (i_weK = 1 and i_hold = 1).
- Arbitration:
  - Combinational over eligible requesters, starting at the pointer, order ptr, ptr+1, ptr+2 mod 3.
  - Winner W is registered.
  - Pointer becomes W+1 mod 3 only when a grant is issued.
- Cycle N+1 outputs, all registered, all for exactly one cycle:
  - o_gntW = 1.
  - o_ram_ce = 1.
  - o_ram_we = i_weW.
  - o_ram_addr = i_addrW.
  - o_ram_din = i_dinW.
- Requester handshake:
  - Requester holds req/we/addr/din stable until it sees o_gnt.
  - It may deassert or present a new request in the o_gnt cycle.
  - Max rate: one grant per requester every 2 cycles; aggregate one grant per cycle.
- Reads:
  - A read granted at cycle N+1 produces o_rvalidW = 1 at cycle N+1+RD_LAT, with o_rdata = i_ram_dout.
  - o_rdata holds its value when no rvalid is asserted.
  - Requester id is tracked through an RD_LAT-deep shift register.
- Out of range (i_addrW >= DEPTH):
  - Grant still issued; o_ram_ce = 0 and o_ram_we = 0.
  - o_err pulses in the grant cycle.
  - A read still returns o_rvalidW at the normal latency, with o_rdata = 0.
- i_hold:
  - Only write grants are suppressed; reads proceed.
  - A write registered before i_hold rises still completes in the next cycle.
  - Blocked writers do not advance the pointer.
- No eligible requester: o_ram_ce = 0, pointer unchanged, no gnt.
- Async reset mid-operation: in-flight rvalids are dropped, no gnt is issued after reset, and the pointer returns to 0.
- o_busy = any i_reqK OR any in-flight read OR any o_gnt this cycle.

Test Plan:
- Reset, then req0 read addr 10 with BRAM[10] = 16'h1234 (RD_LAT = 1) -> o_gnt0 one cycle later; o_rvalid0 with o_rdata = 16'h1234 one cycle after that; other rvalids stay 0.
- req0, req1 and req2 held continuously, all reads -> grant order 0,1,2,0,1,2 on consecutive cycles; each o_gnt exactly one cycle wide; rvalid routed to the matching requester.
- i_hold = 1; req1 write addr 5 data 16'hBEEF; req2 read addr 6 -> req2 granted, req1 not granted while hold = 1. Drop hold -> req1 granted next; BRAM[5] = 16'hBEEF.
- req2 read addr 500 -> o_gnt2 and o_err pulse, o_ram_ce = 0, o_rvalid2 with o_rdata = 0. Addr 499 -> normal access, o_err = 0.
- RD_LAT = 3, back-to-back reads req0 addr 1, then req1 addr 2 -> rvalid0 then rvalid1 on consecutive cycles, each 3 cycles after its grant, with correct data.
- Assert i_rst one cycle after a read grant -> no o_rvalid appears; all outputs 0. After release, pointer = 0, so req0 wins a simultaneous req0/req2 request.
